// File: rtl/mem_bus_arbiter_if.sv
// Request/in-flight/grant bundle between the I-cache, D-cache and the AXI port arbiter.
// master: arbiter side; slave: cache/mux side.
interface mem_bus_arbiter_if;
    logic       icache_request;
    logic       icache_in_flight;
    logic       dcache_request;
    logic       dcache_in_flight;
    logic       snoop_active;
    logic       icache_grant;
    logic       dcache_grant;
    logic [1:0] bus_owner;
    logic       grant_timeout;

    modport master (
        input  icache_request, icache_in_flight, dcache_request, dcache_in_flight, snoop_active,
        output icache_grant, dcache_grant, bus_owner, grant_timeout
    );

    modport slave (
        output icache_request, icache_in_flight, dcache_request, dcache_in_flight, snoop_active,
        input  icache_grant, dcache_grant, bus_owner, grant_timeout
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Arbitrates the shared AXI master port between I-cache and D-cache: D priority,
// bounded I starvation, grant held until the winner's transaction drains.
module mem_bus_arbiter #(
    parameter int unsigned DCACHE_STREAK_MAX = 4,
    parameter int unsigned START_TIMEOUT     = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    mem_bus_arbiter_if.master bus
);
    localparam int unsigned     TW           = $clog2(START_TIMEOUT + 1);
    localparam logic [2:0]      STREAK_MAX   = 3'(DCACHE_STREAK_MAX);
    localparam logic [TW-1:0]   TIMEOUT_LAST = TW'(START_TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, GRANT_I, GRANT_D, RELEASE} state_t;

    state_t        r_state;
    state_t        w_next;
    logic          r_started;
    logic [TW-1:0] r_tcnt;
    logic [2:0]    r_streak;
    logic          r_timeout;
    logic          w_timeout;
    logic          w_req;
    logic          w_inflt;
    logic          w_pick_d;
    logic          w_pick_i;

    // Request/in-flight of whichever cache currently owns the port
    always_comb begin
        w_req   = 1'b0;
        w_inflt = 1'b0;
        if (r_state == GRANT_I) begin
            w_req   = bus.icache_request;
            w_inflt = bus.icache_in_flight;
        end else if (r_state == GRANT_D) begin
            w_req   = bus.dcache_request;
            w_inflt = bus.dcache_in_flight;
        end
    end

    assign w_pick_d = !bus.snoop_active && bus.dcache_request &&
                      (!bus.icache_request || (r_streak < STREAK_MAX));
    assign w_pick_i = !bus.snoop_active && bus.icache_request && !w_pick_d;

    always_comb begin
        w_next    = r_state;
        w_timeout = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_pick_d)      w_next = GRANT_D;
                else if (w_pick_i) w_next = GRANT_I;
            end
            GRANT_I, GRANT_D: begin
                if (r_started) begin
                    if (!w_inflt) w_next = RELEASE;
                end else if (!w_inflt) begin
                    if (!w_req) begin
                        w_next = RELEASE;
                    end else if (r_tcnt == TIMEOUT_LAST) begin
                        w_next    = RELEASE;
                        w_timeout = 1'b1;
                    end
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state   <= IDLE;
            r_started <= 1'b0;
            r_tcnt    <= '0;
            r_streak  <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_timeout <= w_timeout;
            // Only IDLE leads into a grant, so clearing outside GRANT_x clears on entry
            if ((r_state == GRANT_I) || (r_state == GRANT_D)) begin
                if (w_inflt) r_started <= 1'b1;
                if (!r_started && !w_inflt) r_tcnt <= r_tcnt + 1'b1;
            end else begin
                r_started <= 1'b0;
                r_tcnt    <= '0;
            end
            if (r_state == IDLE) begin
                if (w_pick_d) begin
                    if (!bus.icache_request)      r_streak <= '0;
                    else if (r_streak < STREAK_MAX) r_streak <= r_streak + 3'd1;
                end else if (w_pick_i) begin
                    r_streak <= '0;
                end
            end
        end
    end

    assign bus.icache_grant  = (r_state == GRANT_I);
    assign bus.dcache_grant  = (r_state == GRANT_D);
    assign bus.bus_owner     = {bus.dcache_grant, bus.icache_grant};
    assign bus.grant_timeout = r_timeout;
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: per-feature tasks with a queue of expected
// bus owners pushed at stimulus time and popped when the DUT produces its grant.
module tb_mem_bus_arbiter;
    logic clk = 1'b0;
    logic reset_n;
    int   n_total = 0;
    int   n_pass  = 0;
    logic inv_en  = 1'b0;
    logic [1:0] exp_q[$];

    always #5 clk = ~clk;

    mem_bus_arbiter_if bus ();

    mem_bus_arbiter #(
        .DCACHE_STREAK_MAX(4),
        .START_TIMEOUT    (16)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    always @(negedge clk) begin
        if (inv_en) begin
            assert (!(bus.icache_grant && bus.dcache_grant) &&
                    (bus.bus_owner === {bus.dcache_grant, bus.icache_grant}))
            else $error("FAIL invariant ig=%b dg=%b owner=%b", bus.icache_grant,
                        bus.dcache_grant, bus.bus_owner);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        bus.icache_request   = 1'b0;
        bus.icache_in_flight = 1'b0;
        bus.dcache_request   = 1'b0;
        bus.dcache_in_flight = 1'b0;
        bus.snoop_active     = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        bus.icache_request   = 1'b1;
        bus.icache_in_flight = 1'b0;
        bus.dcache_request   = 1'b1;
        bus.dcache_in_flight = 1'b0;
        bus.snoop_active     = 1'b0;
        tick();
        tick();
        inv_en = 1'b1;
        n_total++;
        if (bus.bus_owner !== 2'b00) $display("FAIL reset_owner got=%b exp=00", bus.bus_owner);
        else n_pass++;
        n_total++;
        if ({bus.icache_grant, bus.dcache_grant, bus.grant_timeout} !== 3'b000)
            $display("FAIL reset_grants got ig=%b dg=%b to=%b exp=000", bus.icache_grant,
                     bus.dcache_grant, bus.grant_timeout);
        else n_pass++;
        reset_n = 1'b1;
        tick();
        n_total++;
        if (bus.bus_owner !== 2'b10) $display("FAIL reset_first_grant got=%b exp=10", bus.bus_owner);
        else n_pass++;
    endtask

    typedef struct {
        logic       dreq;
        logic       dinf;
        logic [1:0] own;
    } row_t;

    task automatic test_single_d();
        row_t rows[11] = '{
            '{1'b1, 1'b0, 2'b10}, '{1'b1, 1'b0, 2'b10}, '{1'b0, 1'b1, 2'b10},
            '{1'b0, 1'b1, 2'b10}, '{1'b0, 1'b1, 2'b10}, '{1'b0, 1'b1, 2'b10},
            '{1'b1, 1'b0, 2'b00}, '{1'b1, 1'b0, 2'b00}, '{1'b1, 1'b0, 2'b10},
            '{1'b0, 1'b0, 2'b00}, '{1'b0, 1'b0, 2'b00}
        };
        logic [1:0] exp;
        do_reset();
        for (int k = 0; k < 11; k++) begin
            bus.dcache_request   = rows[k].dreq;
            bus.dcache_in_flight = rows[k].dinf;
            exp_q.push_back(rows[k].own);
            tick();
            exp = exp_q.pop_front();
            n_total++;
            if (bus.bus_owner !== exp || bus.dcache_grant !== exp[1] || bus.icache_grant !== exp[0])
                $display("FAIL single_d cyc%0d got owner=%b dg=%b ig=%b exp owner=%b", k + 1,
                         bus.bus_owner, bus.dcache_grant, bus.icache_grant, exp);
            else n_pass++;
        end
    endtask

    task automatic test_starvation();
        logic [1:0] exp;
        int wc;
        do_reset();
        bus.icache_request = 1'b1;
        bus.dcache_request = 1'b1;
        for (int g = 0; g < 10; g++) exp_q.push_back((g == 4 || g == 9) ? 2'b01 : 2'b10);
        tick();
        for (int g = 0; g < 10; g++) begin
            wc = 0;
            while (bus.bus_owner === 2'b00 && wc < 10) begin
                tick();
                wc++;
            end
            exp = exp_q.pop_front();
            n_total++;
            if (bus.bus_owner !== exp) $display("FAIL starve_grant%0d got=%b exp=%b", g, bus.bus_owner, exp);
            else n_pass++;
            if (bus.bus_owner === 2'b01) bus.icache_in_flight = 1'b1;
            else bus.dcache_in_flight = 1'b1;
            tick();
            tick();
            bus.icache_in_flight = 1'b0;
            bus.dcache_in_flight = 1'b0;
            wc = 0;
            while (bus.bus_owner !== 2'b00 && wc < 10) begin
                tick();
                wc++;
            end
            n_total++;
            if (wc >= 10) $display("FAIL starve_release%0d owner stuck at %b, exp 00", g, bus.bus_owner);
            else n_pass++;
        end
        bus.icache_request = 1'b0;
        bus.dcache_request = 1'b0;
        tick();
        tick();
        tick();
    endtask

    task automatic test_timeout();
        logic [1:0] exp;
        int glen;
        do_reset();
        bus.icache_request = 1'b1;
        bus.dcache_request = 1'b1;
        exp_q.push_back(2'b10);
        exp_q.push_back(2'b01);
        tick();
        exp = exp_q.pop_front();
        n_total++;
        if (bus.bus_owner !== exp) $display("FAIL timeout_first got=%b exp=%b", bus.bus_owner, exp);
        else n_pass++;
        glen = 0;
        while (bus.dcache_grant === 1'b1 && glen < 40) begin
            glen++;
            tick();
        end
        n_total++;
        if (glen != 16) $display("FAIL timeout_len got=%0d cycles exp=16", glen);
        else n_pass++;
        n_total++;
        if (bus.grant_timeout !== 1'b1 || bus.bus_owner !== 2'b00)
            $display("FAIL timeout_pulse got to=%b owner=%b exp to=1 owner=00", bus.grant_timeout,
                     bus.bus_owner);
        else n_pass++;
        bus.dcache_request = 1'b0;
        tick();
        n_total++;
        if (bus.grant_timeout !== 1'b0) $display("FAIL timeout_one_cycle got=%b exp=0", bus.grant_timeout);
        else n_pass++;
        tick();
        exp = exp_q.pop_front();
        n_total++;
        if (bus.bus_owner !== exp) $display("FAIL timeout_then_i got=%b exp=%b", bus.bus_owner, exp);
        else n_pass++;
        bus.icache_request = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_snoop();
        do_reset();
        bus.snoop_active   = 1'b1;
        bus.icache_request = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            n_total++;
            if (bus.bus_owner !== 2'b00) $display("FAIL snoop_block%0d got=%b exp=00", k, bus.bus_owner);
            else n_pass++;
        end
        bus.snoop_active = 1'b0;
        tick();
        n_total++;
        if (bus.bus_owner !== 2'b01) $display("FAIL snoop_release got=%b exp=01", bus.bus_owner);
        else n_pass++;
        bus.icache_request = 1'b0;
        tick();
        tick();
        bus.dcache_request = 1'b1;
        tick();
        n_total++;
        if (bus.bus_owner !== 2'b10) $display("FAIL snoop_dgrant got=%b exp=10", bus.bus_owner);
        else n_pass++;
        bus.snoop_active     = 1'b1;
        bus.dcache_request   = 1'b0;
        bus.dcache_in_flight = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            n_total++;
            if (bus.bus_owner !== 2'b10) $display("FAIL snoop_hold%0d got=%b exp=10", k, bus.bus_owner);
            else n_pass++;
        end
        bus.dcache_in_flight = 1'b0;
        bus.dcache_request   = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            n_total++;
            if (bus.bus_owner !== 2'b00) $display("FAIL snoop_defer%0d got=%b exp=00", k, bus.bus_owner);
            else n_pass++;
        end
        bus.snoop_active = 1'b0;
        tick();
        n_total++;
        if (bus.bus_owner !== 2'b10) $display("FAIL snoop_regrant got=%b exp=10", bus.bus_owner);
        else n_pass++;
        bus.dcache_request = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_reset_mid();
        do_reset();
        bus.dcache_request = 1'b1;
        tick();
        n_total++;
        if (bus.bus_owner !== 2'b10) $display("FAIL midrst_grant got=%b exp=10", bus.bus_owner);
        else n_pass++;
        bus.dcache_request   = 1'b0;
        bus.dcache_in_flight = 1'b1;
        tick();
        n_total++;
        if (bus.dcache_grant !== 1'b1) $display("FAIL midrst_busy got=%b exp=1", bus.dcache_grant);
        else n_pass++;
        reset_n = 1'b0;
        tick();
        n_total++;
        if (bus.bus_owner !== 2'b00 || bus.dcache_grant !== 1'b0)
            $display("FAIL midrst_clear got owner=%b dg=%b exp 00/0", bus.bus_owner, bus.dcache_grant);
        else n_pass++;
        reset_n = 1'b1;
        bus.dcache_in_flight = 1'b0;
        tick();
        n_total++;
        if (bus.bus_owner !== 2'b00) $display("FAIL midrst_idle got=%b exp=00", bus.bus_owner);
        else n_pass++;
    endtask

    initial begin
        reset_n = 1'b0;
        test_reset();
        test_single_d();
        test_starvation();
        test_timeout();
        test_snoop();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
